// File: rtl/serial_alu_driver_pkg.sv
// Shared ALU op-code constants and op classification helpers used by the
// ALU control block and the bit-serial driver.
package serial_alu_driver_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLAGS = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_is_legal = 1'b1;
            default:                                       op_is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_uses_sub(input logic [3:0] op);
        op_uses_sub = (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // SLT is a subtraction whose verdict is formed from the MSB afterwards.
    function automatic logic [3:0] op_cell(input logic [3:0] op);
        op_cell = (op == OP_SLT) ? OP_SUB : op;
    endfunction

endpackage

// File: rtl/serial_alu_driver_one_bit_alu.sv
// MIPS-style one-bit ALU slice: op[3] inverts A, op[2] (or sub) inverts B,
// op[1:0] selects AND / OR / SUM / LESS.
module one_bit_alu (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic       less_i,
    input  logic       sub_i,
    input  logic [3:0] op_i,
    output logic       r_o,
    output logic       cout_o
);

    logic a_eff;
    logic b_eff;
    logic sum;

    always_comb begin
        a_eff  = op_i[3] ? ~a_i : a_i;
        b_eff  = (op_i[2] | sub_i) ? ~b_i : b_i;
        sum    = a_eff ^ b_eff ^ cin_i;
        cout_o = (a_eff & b_eff) | (cin_i & (a_eff ^ b_eff));
        case (op_i[1:0])
            2'd0:    r_o = a_eff & b_eff;
            2'd1:    r_o = a_eff | b_eff;
            2'd2:    r_o = sum;
            default: r_o = less_i;
        endcase
    end

endmodule

// File: rtl/serial_alu_driver.sv
// Bit-serial ALU engine: feeds one one_bit_alu cell LSB first, chaining the
// carry through a register, then forms result and MIPS-style flags.
module serial_alu_driver
    import serial_alu_driver_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             err
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic [CW-1:0]    cnt_q;
    logic             cy_q;
    logic             msb_cin_q;
    logic             msb_r_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             err_q;

    logic             cell_r;
    logic             cell_cout;
    logic             cell_sub_d;
    logic [3:0]       cell_op_d;
    logic             ovf_raw_d;
    logic [WIDTH-1:0] final_result_d;
    logic             final_carry_d;
    logic             final_ovf_d;

    always_comb begin
        cell_sub_d = op_uses_sub(op_q);
        cell_op_d  = op_cell(op_q);
    end

    one_bit_alu u_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (cy_q),
        .less_i (1'b0),
        .sub_i  (cell_sub_d),
        .op_i   (cell_op_d),
        .r_o    (cell_r),
        .cout_o (cell_cout)
    );

    // Flags only mean something for arithmetic; SLT folds overflow into its verdict.
    always_comb begin
        ovf_raw_d      = msb_cin_q ^ cout_q;
        final_result_d = res_sh_q;
        final_carry_d  = 1'b0;
        final_ovf_d    = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                final_carry_d = cout_q;
                final_ovf_d   = ovf_raw_d;
            end
            OP_SLT: begin
                final_result_d    = '0;
                final_result_d[0] = msb_r_q ^ ovf_raw_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_AND;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            cnt_q       <= '0;
            cy_q        <= 1'b0;
            msb_cin_q   <= 1'b0;
            msb_r_q     <= 1'b0;
            cout_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (op_is_legal(op)) begin
                            op_q    <= op;
                            a_sh_q  <= a;
                            b_sh_q  <= b;
                            cnt_q   <= '0;
                            cy_q    <= op_uses_sub(op);
                            busy_q  <= 1'b1;
                            err_q   <= 1'b0;
                            state_q <= ST_RUN;
                        end else begin
                            result_q    <= '0;
                            zero_q      <= 1'b1;
                            carry_out_q <= 1'b0;
                            overflow_q  <= 1'b0;
                            err_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    res_sh_q <= {cell_r, res_sh_q[WIDTH-1:1]};
                    cy_q     <= cell_cout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        msb_cin_q <= cy_q;
                        msb_r_q   <= cell_r;
                        cout_q    <= cell_cout;
                        busy_q    <= 1'b0;
                        state_q   <= ST_FLAGS;
                    end
                end
                ST_FLAGS: begin
                    result_q    <= final_result_d;
                    zero_q      <= (final_result_d == '0);
                    carry_out_q <= final_carry_d;
                    overflow_q  <= final_ovf_d;
                    done_q      <= 1'b1;
                    state_q     <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign err       = err_q;

endmodule
